// File: rtl/i2c_slave_ctrl_if.sv
// Bus-side signal bundle for the I2C slave control stage.
// slave modport: seen by i2c_slave_ctrl; master modport: seen by the bus model / upstream logic.
interface i2c_slave_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             SDA_IN;
  logic             start;
  logic             stop;
  logic             address_match;
  logic             RX;
  logic             ACK;
  logic             MACK;
  logic             byte_req;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;

  modport slave (
    input  SDA_IN, start, stop,
    output address_match, RX, ACK, MACK, byte_req, rx_data, rx_valid
  );

  modport master (
    output SDA_IN, start, stop,
    input  address_match, RX, ACK, MACK, byte_req, rx_data, rx_valid
  );
endinterface

// File: rtl/i2c_slave_ctrl.sv
// I2C slave control stage, clocked on SCL.
// Deserialises the address byte, checks it against OWN_ADDR, tracks direction and
// produces the ACK/MACK/byte_req qualifiers for the transmit shifter; assembles
// bytes written by the master.
// Optional feature macro: GENERAL_CALL_EN -- address byte 8'h00 is also accepted
// as a write to this slave.
module i2c_slave_ctrl #(
  parameter logic [6:0] OWN_ADDR = 7'h42,
  parameter int         WIDTH    = 8
) (
  input  logic                SCL,
  input  logic                RST,
  i2c_slave_ctrl_if.slave     bus
);

  // Counter covers both the 8-bit address phase and a WIDTH-bit data byte.
  localparam int CNT_W = (WIDTH > 8) ? $clog2(WIDTH) : 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE_DATA,
    ST_WRITE_ACK,
    ST_READ_DATA,
    ST_READ_MACK,
    ST_IGNORE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [CNT_W-1:0]   w_bit_cnt_next;
  // Holds the bits received so far; the bit on SDA_IN completes the byte.
  logic [WIDTH-2:0]   r_shift;
  logic [WIDTH-2:0]   w_shift_next;
  logic               r_match;
  logic               w_match_next;
  logic               r_rx;
  logic               w_rx_next;
  logic               r_ack;
  logic               w_ack_next;
  logic               r_mack;
  logic               w_mack_next;
  logic               r_byte_req;
  logic               w_byte_req_next;
  logic [WIDTH-1:0]   r_rx_data;
  logic [WIDTH-1:0]   w_rx_data_next;
  logic               r_rx_valid;
  logic               w_rx_valid_next;

  logic               w_own_hit;
  logic               w_gc_hit;
  logic               w_addr_hit;
  logic [WIDTH-1:0]   w_full_byte;

  assign w_full_byte = {r_shift, bus.SDA_IN};
  // Address is the first seven bits shifted in; the bit on SDA_IN is R/W.
  assign w_own_hit   = (r_shift[6:0] == OWN_ADDR);
`ifdef GENERAL_CALL_EN
  assign w_gc_hit    = (r_shift[6:0] == 7'h00) && !bus.SDA_IN;
`else
  assign w_gc_hit    = 1'b0;
`endif
  assign w_addr_hit  = w_own_hit || w_gc_hit;

  // State and output registers; active-low synchronous reset.
  always_ff @(posedge SCL) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_match    <= 1'b0;
      r_rx       <= 1'b0;
      r_ack      <= 1'b0;
      r_mack     <= 1'b0;
      r_byte_req <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
      r_match    <= w_match_next;
      r_rx       <= w_rx_next;
      r_ack      <= w_ack_next;
      r_mack     <= w_mack_next;
      r_byte_req <= w_byte_req_next;
      r_rx_data  <= w_rx_data_next;
      r_rx_valid <= w_rx_valid_next;
    end
  end

  // Next-state and output decode; START beats STOP beats the normal sequence.
  always_comb begin
    w_state_next    = r_state;
    w_bit_cnt_next  = r_bit_cnt;
    w_shift_next    = r_shift;
    w_match_next    = r_match;
    w_rx_next       = r_rx;
    w_mack_next     = r_mack;
    w_rx_data_next  = r_rx_data;
    // ACK, byte_req and rx_valid are single-cycle strobes.
    w_ack_next      = 1'b0;
    w_byte_req_next = 1'b0;
    w_rx_valid_next = 1'b0;

    if (bus.start) begin
      w_state_next   = ST_ADDR;
      w_bit_cnt_next = '0;
      w_match_next   = 1'b0;
      w_rx_next      = 1'b0;
      w_mack_next    = 1'b0;
    end else if (bus.stop) begin
      w_state_next   = ST_IDLE;
      w_bit_cnt_next = '0;
      w_match_next   = 1'b0;
      w_rx_next      = 1'b0;
      w_mack_next    = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_bit_cnt_next = '0;
        end
        ST_ADDR: begin
          w_shift_next = w_full_byte[WIDTH-2:0];
          if (r_bit_cnt == CNT_W'(7)) begin
            w_bit_cnt_next = '0;
            if (w_addr_hit) begin
              w_match_next = 1'b1;
              // General call is always a write regardless of the R/W bit.
              w_rx_next    = bus.SDA_IN && !w_gc_hit;
              w_ack_next   = 1'b1;
              w_state_next = ST_ADDR_ACK;
            end else begin
              w_match_next = 1'b0;
              w_rx_next    = 1'b0;
              w_mack_next  = 1'b0;
              w_state_next = ST_IGNORE;
            end
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
        ST_ADDR_ACK: begin
          w_bit_cnt_next = '0;
          if (r_rx) begin
            // Prime the transmit shifter with the first byte.
            w_byte_req_next = 1'b1;
            w_mack_next     = 1'b1;
            w_state_next    = ST_READ_DATA;
          end else begin
            w_state_next    = ST_WRITE_DATA;
          end
        end
        ST_WRITE_DATA: begin
          w_shift_next = w_full_byte[WIDTH-2:0];
          if (r_bit_cnt == CNT_W'(WIDTH - 1)) begin
            w_bit_cnt_next  = '0;
            w_rx_data_next  = w_full_byte;
            w_rx_valid_next = 1'b1;
            w_ack_next      = 1'b1;
            w_state_next    = ST_WRITE_ACK;
          end else begin
            w_bit_cnt_next  = r_bit_cnt + 1'b1;
          end
        end
        ST_WRITE_ACK: begin
          w_bit_cnt_next = '0;
          w_state_next   = ST_WRITE_DATA;
        end
        ST_READ_DATA: begin
          if (r_bit_cnt == CNT_W'(WIDTH - 1)) begin
            w_bit_cnt_next = '0;
            w_state_next   = ST_READ_MACK;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
        ST_READ_MACK: begin
          w_bit_cnt_next = '0;
          if (!bus.SDA_IN) begin
            w_mack_next     = 1'b1;
            w_byte_req_next = 1'b1;
            w_state_next    = ST_READ_DATA;
          end else begin
            // Master NACK ends the read; stay quiet until START/STOP.
            w_mack_next     = 1'b0;
            w_match_next    = 1'b0;
            w_rx_next       = 1'b0;
            w_state_next    = ST_IGNORE;
          end
        end
        ST_IGNORE: begin
          w_bit_cnt_next = '0;
          w_match_next   = 1'b0;
          w_rx_next      = 1'b0;
          w_mack_next    = 1'b0;
        end
        default: begin
          w_state_next   = ST_IDLE;
          w_bit_cnt_next = '0;
        end
      endcase
    end
  end

  assign bus.address_match = r_match;
  assign bus.RX            = r_rx;
  assign bus.ACK           = r_ack;
  assign bus.MACK          = r_mack;
  assign bus.byte_req      = r_byte_req;
  assign bus.rx_data       = r_rx_data;
  assign bus.rx_valid      = r_rx_valid;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Self-checking bench for i2c_slave_ctrl: directed scenarios followed by random
// transactions, checked against a transaction-level expectation of the protocol.
module tb_i2c_slave_ctrl;

  localparam logic [6:0] OWN_ADDR = 7'h42;
  localparam int         WIDTH    = 8;
`ifdef GENERAL_CALL_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic SCL;
  logic RST;
  int   n_checks;
  int   n_pass;
  logic [WIDTH-1:0] last_rx;

  i2c_slave_ctrl_if #(.WIDTH(WIDTH)) bus ();

  i2c_slave_ctrl #(.OWN_ADDR(OWN_ADDR), .WIDTH(WIDTH)) dut (
    .SCL (SCL),
    .RST (RST),
    .bus (bus)
  );

  initial SCL = 1'b0;
  always #5 SCL = ~SCL;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Whether an address byte should be accepted, from the protocol rules.
  function automatic bit addr_accepts(input logic [7:0] b);
    return (b[7:1] == OWN_ADDR) || (GC_EN && b == 8'h00);
  endfunction

  function automatic logic [5:0] strobes();
    return {bus.address_match, bus.RX, bus.ACK, bus.MACK, bus.byte_req, bus.rx_valid};
  endfunction

  task automatic tick();
    @(posedge SCL);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.SDA_IN = b;
    tick();
  endtask

  task automatic do_start();
    bus.start  = 1'b1;
    bus.SDA_IN = 1'($urandom);
    tick();
    bus.start  = 1'b0;
    check("start_clear", 32'(strobes()), 32'd0);
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("stop_clear", 32'(strobes()), 32'd0);
    check("rx_data_kept", 32'(bus.rx_data), 32'(last_rx));
  endtask

  task automatic send_addr(input logic [7:0] b, output bit hit);
    logic early;
    early = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      if (i > 0) early = early | bus.ACK | bus.address_match;
    end
    hit = addr_accepts(b);
    check("addr_early", 32'(early), 32'd0);
    check("addr_ack", 32'(bus.ACK), 32'(hit));
    check("addr_match", 32'(bus.address_match), 32'(hit));
    check("addr_rx", 32'(bus.RX), 32'(hit & b[0]));
  endtask

  // Master writes n bytes; abort_at>0 stops after that many bits of the first byte.
  task automatic write_bytes(input int n, input int abort_at);
    logic [7:0] d;
    logic       early;
    send_bit(1'($urandom));
    check("wr_aack_drop", 32'({bus.ACK, bus.rx_valid, bus.byte_req}), 32'd0);
    for (int k = 0; k < n; k++) begin
      d = 8'($urandom);
      early = 1'b0;
      for (int i = 7; i >= 0; i--) begin
        if (abort_at > 0 && k == 0 && (7 - i) == abort_at) begin
          check("wr_abort_quiet", 32'(early), 32'd0);
          return;
        end
        send_bit(d[i]);
        if (i > 0) early = early | bus.rx_valid | bus.ACK;
      end
      check("wr_early", 32'(early), 32'd0);
      check("wr_valid", 32'(bus.rx_valid), 32'd1);
      check("wr_data", 32'(bus.rx_data), 32'(d));
      check("wr_ack", 32'(bus.ACK), 32'd1);
      last_rx = d;
      send_bit(1'($urandom));
      check("wr_ack_drop", 32'({bus.ACK, bus.rx_valid}), 32'd0);
      check("wr_hold", 32'({bus.address_match, bus.RX}), 32'b10);
    end
  endtask

  // Master reads n bytes, ACKing all but the last, which it NACKs.
  task automatic read_bytes(input int n);
    int   reqs;
    logic mack_drop;
    logic extra;
    reqs = 0;
    send_bit(1'($urandom));
    check("rd_first_req", 32'({bus.byte_req, bus.MACK, bus.ACK}), 32'b110);
    reqs += int'(bus.byte_req);
    for (int k = 0; k < n; k++) begin
      mack_drop = 1'b0;
      extra = 1'b0;
      for (int i = 0; i < 8; i++) begin
        send_bit(1'($urandom));
        mack_drop = mack_drop | ~bus.MACK;
        extra = extra | bus.byte_req | bus.ACK | bus.rx_valid;
      end
      check("rd_mack_hold", 32'(mack_drop), 32'd0);
      check("rd_quiet", 32'(extra), 32'd0);
      if (k < n - 1) begin
        send_bit(1'b0);
        check("rd_mack_ack", 32'({bus.MACK, bus.byte_req}), 32'b11);
      end else begin
        send_bit(1'b1);
        check("rd_nack", 32'({bus.MACK, bus.byte_req, bus.address_match}), 32'd0);
      end
      reqs += int'(bus.byte_req);
    end
    check("rd_req_count", 32'(reqs), 32'(n));
  endtask

  task automatic ignore_bits(input int n);
    logic any;
    any = 1'b0;
    for (int i = 0; i < n; i++) begin
      send_bit(1'($urandom));
      any = any | (|strobes());
    end
    check("ignore_quiet", 32'(any), 32'd0);
  endtask

  // One full transaction from START; ends with STOP when with_stop is set.
  task automatic run_txn(input int id, input logic [7:0] b, input int n, input bit with_stop);
    bit hit;
    $display("txn %0d addr=%02h bytes=%0d expect_hit=%0d", id, b, n, addr_accepts(b));
    do_start();
    send_addr(b, hit);
    if (hit && !b[0])     write_bytes(n, 0);
    else if (hit && b[0]) begin
      read_bytes(n);
      ignore_bits(4);
    end else              ignore_bits(9 * n);
    if (with_stop) do_stop();
  endtask

  initial begin
    bit hit;
    logic [7:0] b;
    n_checks   = 0;
    n_pass     = 0;
    last_rx    = '0;
    RST        = 1'b0;
    bus.SDA_IN = 1'b0;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    tick();
    tick();
    check("reset_strobes", 32'(strobes()), 32'd0);
    check("reset_rx_data", 32'(bus.rx_data), 32'd0);
    RST = 1'b1;

    run_txn(1, 8'h84, 2, 1'b1);
    run_txn(2, 8'h85, 3, 1'b1);
    run_txn(3, 8'h90, 2, 1'b1);

    // Reset during an address shift; the slave must then ignore a byte without START.
    $display("txn 4 reset during address shift");
    do_start();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    RST = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    last_rx = '0;
    check("midrst_strobes", 32'(strobes()), 32'd0);
    check("midrst_rx_data", 32'(bus.rx_data), 32'd0);
    b = 8'h84;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    check("idle_no_ack", 32'(strobes()), 32'd0);
    run_txn(5, 8'h84, 1, 1'b1);

    // Repeated START in the middle of a written byte.
    $display("txn 6 repeated start mid write byte");
    do_start();
    send_addr(8'h84, hit);
    write_bytes(1, 4);
    do_start();
    send_addr(8'h85, hit);
    read_bytes(2);
    do_stop();

    run_txn(7, 8'h00, 1, 1'b1);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0, 1:    b = {OWN_ADDR, 1'b0};
        2, 3:    b = {OWN_ADDR, 1'b1};
        4:       b = 8'($urandom);
        default: b = 8'h00;
      endcase
      run_txn(8 + t, b, int'($urandom_range(1, 4)), 1'($urandom));
    end
    do_stop();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_ctrl.md
Name: i2c_slave_ctrl

Overview:
- Upstream control stage of the I2C slave datapath, clocked on SCL.
- Deserialises the address byte and compares it with the slave's own 7-bit address, then tracks the transfer direction.
- Produces the address_match, RX, ACK and MACK qualifiers that the slave-to-master transmit shifter consumes.
- On master writes, also assembles received data bytes; on reads, requests each next transmit byte from the system.

Parameters:
- OWN_ADDR, 7'h42, slave 7-bit address.
- WIDTH, 8, data byte width (address phase is always 8 bits: 7 address + R/W).

Ports:
- SCL  input  1  I2C serial clock; all logic on posedge SCL.
- RST  input  1  synchronous active-low reset, sampled on posedge SCL.
- SDA_IN  input  1  sampled SDA line level.
- start  input  1  START/repeated-START flag from the bus condition detector, valid at a posedge.
- stop  input  1  STOP flag from the bus condition detector.
- address_match  output  1  address byte matched OWN_ADDR; held for the transaction.
- RX  output  1  R/W bit of the matched address byte; 1 = master read, slave transmits.
- ACK  output  1  slave drives ACK (SDA low) during this SCL cycle.
- MACK  output  1  master acknowledged the last transmitted byte; transmit continues.
- byte_req  output  1  one-cycle pulse requesting the next transmit byte.
- rx_data  output  WIDTH  last byte written by the master.
- rx_valid  output  1  one-cycle pulse when rx_data updates.

Behaviour:
- Priority at each posedge: RST=0, then start, then stop, then normal FSM.
- Reset: state=IDLE, bit_cnt=0, shift register=0, all outputs 0.
- start, from any state: go to ADDR with bit_cnt=0; clear address_match, RX, ACK, MACK, byte_req and rx_valid.
- stop, from any state: go to IDLE and clear the same outputs; rx_data retains its value.
- IDLE: ignore SDA_IN; wait for start.
- ADDR:
  - Shift SDA_IN in MSB-first, bit_cnt 0..7.
  - On bit_cnt=7, compare {sh[6:0]} (including the current bit as the R/W bit) as addr=sh[6:0] against OWN_ADDR.
  - Match: address_match=1, RX=current bit, ACK=1, go to ADDR_ACK.
  - Mismatch: go to IGNORE with all outputs 0.
- ADDR_ACK: one cycle.
  - ACK returns to 0 on the next edge; bit_cnt=0.
  - RX=1: go to READ_DATA, byte_req=1 for one cycle, MACK=1 so the downstream shifter loads and shifts the first byte.
  - RX=0: go to WRITE_DATA.
- WRITE_DATA:
  - Shift 8 bits.
  - On the 8th bit: rx_data=assembled byte, rx_valid=1 for one cycle, ACK=1, go to WRITE_ACK.
- WRITE_ACK: ACK=0, bit_cnt=0, back to WRITE_DATA. Byte count is unlimited.
- READ_DATA: count 8 SCL cycles with SDA_IN ignored; MACK holds its value; after the 8th, go to READ_MACK.
- READ_MACK: sample SDA_IN.
  - 0: MACK=1, byte_req pulse, bit_cnt=0, back to READ_DATA.
  - 1 (NACK): MACK=0, go to IGNORE.
- IGNORE: outputs 0 except rx_data; wait for start or stop.
- bit_cnt is 3 bits and never wraps past 7 inside a byte state; it resets on every state entry.
- Repeated START mid-byte aborts the byte: rx_valid does not fire.
- Reset mid-transfer forces IDLE on that edge.

Optional Feature:
- GENERAL_CALL_EN defined: address byte 8'h00 also matches, with address_match=1, RX forced 0, and a write flow identical to the normal write path.
- Undefined: 8'h00 is a mismatch and goes to IGNORE.

Test Plan:
- Reset: RST=0 for 2 edges during an address shift -> all outputs 0, state IDLE; next start and byte 8'h84 -> ACK=1 after the 8th edge.
- Write: start, 8'h84, data 8'hA5, 8'h3C -> address_match=1, RX=0; rx_valid pulses with rx_data=8'hA5 then 8'h3C; ACK high one cycle after each byte; stop -> address_match=0.
- Read: start, 8'h85, master ACK, ACK, NACK -> RX=1; byte_req pulses 3 times; MACK=1 through bytes 1-2 and 0 after the NACK; state IGNORE until stop.
- Mismatch: start, 8'h90 -> no ACK, address_match=0, and no rx_valid for the following bytes.
- Repeated start: during write byte bit 4, start then 8'h85 -> no rx_valid; read flow proceeds with RX=1.
- General call: 8'h00 with GENERAL_CALL_EN -> ACK=1, RX=0; without the macro -> no ACK.
